// File: rtl/gmii_rx_pkt_write.sv
//==============================================================================
// Module   : gmii_rx_pkt_write
// Function : GMII receive framer. Strips preamble/SFD, packs frame bytes into
//            134-bit buffer-memory words (2-bit position flag, 4-bit invalid
//            tail byte count, 128-bit data), writes them to the buffer named
//            by a free bufid, and issues a descriptor for good frames or a
//            release for bad ones.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module gmii_rx_pkt_write (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [7:0]   iv_gmii_rxd,
  input  logic         i_gmii_rx_dv,
  input  logic         i_gmii_rx_er,
  input  logic [8:0]   iv_free_bufid,
  input  logic         i_free_bufid_valid,
  output logic         o_free_bufid_rd,
  output logic [133:0] ov_pkt_wdata,
  output logic [15:0]  ov_pkt_waddr,
  output logic         o_pkt_wr,
  output logic [8:0]   ov_desc_bufid,
  output logic [11:0]  ov_desc_len,
  output logic         o_desc_wr,
  output logic [8:0]   ov_rel_bufid,
  output logic         o_rel_wr,
  output logic         o_inpkt_pulse,
  output logic         o_err_pulse,
  output logic         o_nobuf_pulse,
  output logic [1:0]   ov_rx_state
);

  localparam logic [1:0]  IDLE     = 2'd0;
  localparam logic [1:0]  PREAMBLE = 2'd1;
  localparam logic [1:0]  DATA     = 2'd2;
  localparam logic [1:0]  DROP     = 2'd3;

  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;

  localparam logic [11:0] MIN_LEN  = 12'd64;
  localparam logic [11:0] MAX_LEN  = 12'd2048;
  localparam logic [11:0] SAT_LEN  = 12'd2049;

  localparam logic [1:0]  FLAG_HEAD = 2'b01;
  localparam logic [1:0]  FLAG_MID  = 2'b11;
  localparam logic [1:0]  FLAG_TAIL = 2'b10;

  // Framing state
  logic [1:0]   state_q, state_d;
  logic [8:0]   bufid_q, bufid_d;
  logic [11:0]  len_q, len_d;
  logic [127:0] acc_q, acc_d;
  logic         err_q, err_d;

  // Registered outputs
  logic [133:0] pkt_wdata_q, pkt_wdata_d;
  logic [15:0]  pkt_waddr_q, pkt_waddr_d;
  logic         pkt_wr_q, pkt_wr_d;
  logic [8:0]   desc_bufid_q, desc_bufid_d;
  logic [11:0]  desc_len_q, desc_len_d;
  logic         desc_wr_q, desc_wr_d;
  logic [8:0]   rel_bufid_q, rel_bufid_d;
  logic         rel_wr_q, rel_wr_d;
  logic         inpkt_q, inpkt_d;
  logic         errp_q, errp_d;
  logic         nobuf_q, nobuf_d;

  logic         bufid_rd;

  // Byte position inside the current 16-byte word, MSB-first
  logic [6:0]   byte_hi;
  // Index of the word that the next sampled byte closes off
  logic [6:0]   lazy_idx;
  // Index of the word holding the last byte of the frame
  logic [6:0]   tail_idx;
  logic [3:0]   tail_inv;
  logic         word_boundary;
  logic         len_ok;

  assign byte_hi       = 7'd127 - {len_q[3:0], 3'b000};
  assign lazy_idx      = len_q[10:4] - 7'd1;
  assign tail_idx      = len_q[10:4] - {6'd0, (len_q[3:0] == 4'd0)};
  assign tail_inv      = 4'd0 - len_q[3:0];
  assign word_boundary = (len_q[3:0] == 4'd0) && (len_q != 12'd0) && (len_q <= MAX_LEN);
  assign len_ok        = (len_q >= MIN_LEN) && (len_q <= MAX_LEN);

  // Next-state and output-event decode for the receive FSM
  always_comb begin
    state_d      = state_q;
    bufid_d      = bufid_q;
    len_d        = len_q;
    acc_d        = acc_q;
    err_d        = err_q;
    pkt_wdata_d  = pkt_wdata_q;
    pkt_waddr_d  = pkt_waddr_q;
    pkt_wr_d     = 1'b0;
    desc_bufid_d = desc_bufid_q;
    desc_len_d   = desc_len_q;
    desc_wr_d    = 1'b0;
    rel_bufid_d  = rel_bufid_q;
    rel_wr_d     = 1'b0;
    inpkt_d      = 1'b0;
    errp_d       = 1'b0;
    nobuf_d      = 1'b0;
    bufid_rd     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_gmii_rx_dv) begin
          state_d = (iv_gmii_rxd == PRE_BYTE) ? PREAMBLE : DROP;
        end
      end

      PREAMBLE: begin
        if (!i_gmii_rx_dv) begin
          state_d = IDLE;
        end else if (iv_gmii_rxd == PRE_BYTE) begin
          state_d = PREAMBLE;
        end else if (iv_gmii_rxd == SFD_BYTE) begin
          if (i_free_bufid_valid) begin
            // Show-ahead FIFO: take the head now and pop it on this edge
            bufid_rd = 1'b1;
            bufid_d  = iv_free_bufid;
            len_d    = 12'd0;
            err_d    = 1'b0;
            acc_d    = 128'd0;
            state_d  = DATA;
          end else begin
            nobuf_d  = 1'b1;
            state_d  = DROP;
          end
        end else begin
          state_d = DROP;
        end
      end

      DATA: begin
        if (i_gmii_rx_dv) begin
          len_d = (len_q == SAT_LEN) ? SAT_LEN : len_q + 12'd1;
          err_d = err_q | i_gmii_rx_er;
          if (len_q[3:0] == 4'd0) begin
            // First byte of a fresh word; stale bytes are cleared
            acc_d = {iv_gmii_rxd, 120'd0};
          end else begin
            acc_d[byte_hi -: 8] = iv_gmii_rxd;
          end
          // The previous word is complete only once a byte spills into the next
          if (word_boundary && !err_q && !i_gmii_rx_er) begin
            pkt_wr_d    = 1'b1;
            pkt_waddr_d = {bufid_q, lazy_idx};
            pkt_wdata_d = {((lazy_idx == 7'd0) ? FLAG_HEAD : FLAG_MID), 4'd0, acc_q};
          end
        end else begin
          state_d = IDLE;
          if (len_ok && !err_q && !i_gmii_rx_er) begin
            pkt_wr_d     = 1'b1;
            pkt_waddr_d  = {bufid_q, tail_idx};
            pkt_wdata_d  = {FLAG_TAIL, tail_inv, acc_q};
            desc_wr_d    = 1'b1;
            inpkt_d      = 1'b1;
            desc_bufid_d = bufid_q;
            desc_len_d   = len_q;
          end else begin
            rel_wr_d     = 1'b1;
            errp_d       = 1'b1;
            rel_bufid_d  = bufid_q;
          end
        end
      end

      DROP: begin
        if (!i_gmii_rx_dv) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any frame in flight silently
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      bufid_q      <= 9'd0;
      len_q        <= 12'd0;
      acc_q        <= 128'd0;
      err_q        <= 1'b0;
      pkt_wdata_q  <= 134'd0;
      pkt_waddr_q  <= 16'd0;
      pkt_wr_q     <= 1'b0;
      desc_bufid_q <= 9'd0;
      desc_len_q   <= 12'd0;
      desc_wr_q    <= 1'b0;
      rel_bufid_q  <= 9'd0;
      rel_wr_q     <= 1'b0;
      inpkt_q      <= 1'b0;
      errp_q       <= 1'b0;
      nobuf_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      bufid_q      <= bufid_d;
      len_q        <= len_d;
      acc_q        <= acc_d;
      err_q        <= err_d;
      pkt_wdata_q  <= pkt_wdata_d;
      pkt_waddr_q  <= pkt_waddr_d;
      pkt_wr_q     <= pkt_wr_d;
      desc_bufid_q <= desc_bufid_d;
      desc_len_q   <= desc_len_d;
      desc_wr_q    <= desc_wr_d;
      rel_bufid_q  <= rel_bufid_d;
      rel_wr_q     <= rel_wr_d;
      inpkt_q      <= inpkt_d;
      errp_q       <= errp_d;
      nobuf_q      <= nobuf_d;
    end
  end

  // Outputs read as zero throughout any reset cycle, not just after it
  assign o_free_bufid_rd = bufid_rd & ~i_rst;
  assign ov_pkt_wdata    = i_rst ? 134'd0 : pkt_wdata_q;
  assign ov_pkt_waddr    = i_rst ? 16'd0  : pkt_waddr_q;
  assign o_pkt_wr        = pkt_wr_q  & ~i_rst;
  assign ov_desc_bufid   = i_rst ? 9'd0   : desc_bufid_q;
  assign ov_desc_len     = i_rst ? 12'd0  : desc_len_q;
  assign o_desc_wr       = desc_wr_q & ~i_rst;
  assign ov_rel_bufid    = i_rst ? 9'd0   : rel_bufid_q;
  assign o_rel_wr        = rel_wr_q  & ~i_rst;
  assign o_inpkt_pulse   = inpkt_q   & ~i_rst;
  assign o_err_pulse     = errp_q    & ~i_rst;
  assign o_nobuf_pulse   = nobuf_q   & ~i_rst;
  assign ov_rx_state     = i_rst ? IDLE : state_q;

endmodule

`default_nettype wire

// File: tb/tb_gmii_rx_pkt_write.sv
//==============================================================================
// Module   : tb_gmii_rx_pkt_write
// Function : Randomized scoreboard bench for gmii_rx_pkt_write. A frame-level
//            model predicts buffer words, descriptors and releases; a monitor
//            compares them as the DUT emits them.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gmii_rx_pkt_write;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [7:0]   iv_gmii_rxd;
  logic         i_gmii_rx_dv;
  logic         i_gmii_rx_er;
  logic [8:0]   iv_free_bufid;
  logic         i_free_bufid_valid;
  logic         o_free_bufid_rd;
  logic [133:0] ov_pkt_wdata;
  logic [15:0]  ov_pkt_waddr;
  logic         o_pkt_wr;
  logic [8:0]   ov_desc_bufid;
  logic [11:0]  ov_desc_len;
  logic         o_desc_wr;
  logic [8:0]   ov_rel_bufid;
  logic         o_rel_wr;
  logic         o_inpkt_pulse;
  logic         o_err_pulse;
  logic         o_nobuf_pulse;
  logic [1:0]   ov_rx_state;

  always #4 i_clk = ~i_clk;

  gmii_rx_pkt_write u_dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .iv_gmii_rxd        (iv_gmii_rxd),
    .i_gmii_rx_dv       (i_gmii_rx_dv),
    .i_gmii_rx_er       (i_gmii_rx_er),
    .iv_free_bufid      (iv_free_bufid),
    .i_free_bufid_valid (i_free_bufid_valid),
    .o_free_bufid_rd    (o_free_bufid_rd),
    .ov_pkt_wdata       (ov_pkt_wdata),
    .ov_pkt_waddr       (ov_pkt_waddr),
    .o_pkt_wr           (o_pkt_wr),
    .ov_desc_bufid      (ov_desc_bufid),
    .ov_desc_len        (ov_desc_len),
    .o_desc_wr          (o_desc_wr),
    .ov_rel_bufid       (ov_rel_bufid),
    .o_rel_wr           (o_rel_wr),
    .o_inpkt_pulse      (o_inpkt_pulse),
    .o_err_pulse        (o_err_pulse),
    .o_nobuf_pulse      (o_nobuf_pulse),
    .ov_rx_state        (ov_rx_state)
  );

  typedef struct packed {
    logic [15:0]  addr;
    logic [133:0] data;
  } wr_t;

  wr_t         wq[$];
  logic [20:0] dq[$];
  logic [8:0]  relq[$];
  int          rd_exp = 0, rd_seen = 0;
  int          nobuf_exp = 0, nobuf_seen = 0;
  int          checks = 0, errors = 0;
  logic [7:0]  fb [0:2199];

  wr_t         mon_w;
  logic [20:0] mon_d;
  logic [8:0]  mon_r;

  task automatic chk(input string nm, input logic [149:0] act, input logic [149:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: data of word k of an L-byte frame, first byte in the MSBs
  function automatic logic [127:0] mkword(input int k, input int L);
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < 16; i++)
      if (16 * k + i < L) w[127 - 8 * i -: 8] = fb[16 * k + i];
    return w;
  endfunction

  // Reference: everything the DUT should emit for one accepted frame.
  // cut >= 0 means reset is asserted in the cycle byte 'cut' would appear.
  task automatic model_frame(input int L, input int er_pos, input logic [8:0] bid, input int cut);
    bit   err;
    int   m;
    int   t;
    wr_t  w;
    err = (er_pos >= 0 && er_pos < L) || L < 64 || L > 2048;
    for (int k = 0; 16 * (k + 1) <= L - 1; k++) begin
      m = 16 * (k + 1);
      if (m > 2048) break;
      if (er_pos >= 0 && er_pos <= m) break;
      if (cut >= 0 && m > cut - 2) break;
      w.addr = {bid, 7'(k)};
      w.data = {(k == 0) ? 2'b01 : 2'b11, 4'd0, mkword(k, L)};
      wq.push_back(w);
    end
    if (cut < 0) begin
      if (!err) begin
        t = (L - 1) / 16;
        w.addr = {bid, 7'(t)};
        w.data = {2'b10, 4'((16 - L % 16) % 16), mkword(t, L)};
        wq.push_back(w);
        dq.push_back({bid, 12'(L)});
      end else begin
        relq.push_back(bid);
      end
    end
  endtask

  task automatic cyc(input logic dv, input logic [7:0] d, input logic er);
    i_gmii_rx_dv = dv;
    iv_gmii_rxd  = d;
    i_gmii_rx_er = er;
    @(posedge i_clk);
    #1;
  endtask

  task automatic fill_seq(input int L);
    for (int n = 0; n < L; n++) fb[n] = 8'(n);
  endtask

  task automatic fill_rand(input int L);
    for (int n = 0; n < L; n++) fb[n] = 8'($urandom);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_wdata"}, 150'(ov_pkt_wdata), 150'd0);
    chk({nm, "_misc"}, 150'({ov_pkt_waddr, ov_desc_bufid, ov_desc_len, ov_rel_bufid, ov_rx_state,
                             o_free_bufid_rd, o_pkt_wr, o_desc_wr, o_rel_wr, o_inpkt_pulse,
                             o_err_pulse, o_nobuf_pulse}), 150'd0);
  endtask

  task automatic send_frame(input int L, input int er_pos, input logic [8:0] bid,
                            input bit valid, input int cut);
    repeat (2 + $urandom_range(0, 3)) cyc(1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
    repeat (7) cyc(1'b1, 8'h55, 1'($urandom_range(0, 1)));
    iv_free_bufid      = bid;
    i_free_bufid_valid = valid;
    if (valid) begin
      rd_exp++;
      model_frame(L, er_pos, bid, cut);
    end else begin
      nobuf_exp++;
    end
    cyc(1'b1, 8'hD5, 1'b0);
    chk(valid ? "state_data" : "state_drop", 150'(ov_rx_state), valid ? 150'd2 : 150'd3);
    iv_free_bufid      = 9'($urandom);
    i_free_bufid_valid = 1'($urandom_range(0, 1));
    for (int n = 0; n < L; n++) begin
      if (n == cut) begin
        i_rst        = 1'b1;
        i_gmii_rx_dv = 1'b0;
        @(negedge i_clk);
        check_all_zero("rst_cycle");
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check_all_zero("post_rst");
        @(posedge i_clk);
        #1;
        repeat (3) cyc(1'b0, 8'h00, 1'b0);
        return;
      end
      cyc(1'b1, fb[n], valid ? (n == er_pos) : 1'($urandom_range(0, 1)));
    end
    cyc(1'b0, 8'h00, 1'b0);
    repeat (3) cyc(1'b0, 8'($urandom), 1'b0);
  endtask

  // Non-0x55 first byte: whole burst must be swallowed
  task automatic send_junk(input int L);
    cyc(1'b1, 8'h12, 1'b0);
    chk("junk_drop", 150'(ov_rx_state), 150'd3);
    repeat (L) cyc(1'b1, 8'hD5, 1'($urandom_range(0, 1)));
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
  endtask

  // Scoreboard monitor, sampling on the falling edge
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_pkt_wr) begin
        if (wq.size() == 0) chk("unexpected_wr", 150'(o_pkt_wr), 150'd0);
        else begin
          mon_w = wq.pop_front();
          chk("wr_addr", 150'(ov_pkt_waddr), 150'(mon_w.addr));
          chk("wr_data", 150'(ov_pkt_wdata), 150'(mon_w.data));
        end
      end
      if (o_desc_wr) begin
        if (dq.size() == 0) chk("unexpected_desc", 150'(o_desc_wr), 150'd0);
        else begin
          mon_d = dq.pop_front();
          chk("desc", 150'({ov_desc_bufid, ov_desc_len}), 150'(mon_d));
          chk("inpkt_with_desc", 150'(o_inpkt_pulse), 150'd1);
        end
      end else if (o_inpkt_pulse) begin
        chk("inpkt_alone", 150'(o_inpkt_pulse), 150'd0);
      end
      if (o_rel_wr) begin
        if (relq.size() == 0) chk("unexpected_rel", 150'(o_rel_wr), 150'd0);
        else begin
          mon_r = relq.pop_front();
          chk("rel_bufid", 150'(ov_rel_bufid), 150'(mon_r));
          chk("err_with_rel", 150'(o_err_pulse), 150'd1);
        end
      end else if (o_err_pulse) begin
        chk("err_alone", 150'(o_err_pulse), 150'd0);
      end
      if (o_free_bufid_rd) rd_seen++;
      if (o_nobuf_pulse)   nobuf_seen++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int L;
    int er;
    i_rst              = 1'b1;
    iv_gmii_rxd        = 8'h00;
    i_gmii_rx_dv       = 1'b0;
    i_gmii_rx_er       = 1'b0;
    iv_free_bufid      = 9'd0;
    i_free_bufid_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    @(negedge i_clk);
    check_all_zero("reset");
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    fill_seq(64);   send_frame(64, -1, 9'h005, 1'b1, -1);
    fill_seq(65);   send_frame(65, -1, 9'h0A3, 1'b1, -1);
    fill_rand(100); send_frame(100, 30, 9'h111, 1'b1, -1);
    fill_rand(50);  send_frame(50, -1, 9'h022, 1'b0, -1);
    fill_rand(60);  send_frame(60, -1, 9'h033, 1'b1, -1);
    fill_rand(2100); send_frame(2100, -1, 9'h1FF, 1'b1, -1);
    fill_rand(2048); send_frame(2048, -1, 9'h044, 1'b1, -1);
    fill_rand(2049); send_frame(2049, -1, 9'h055, 1'b1, -1);
    send_junk(20);
    fill_rand(64);  send_frame(64, -1, 9'h066, 1'b1, 20);
    fill_seq(64);   send_frame(64, -1, 9'h005, 1'b1, -1);
    fill_rand(80);  send_frame(80, 16, 9'h077, 1'b1, -1);
    fill_rand(0);   send_frame(0, -1, 9'h088, 1'b1, -1);

    for (int f = 0; f < 25; f++) begin
      L  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 70)) : int'($urandom_range(60, 260));
      er = ($urandom_range(0, 4) == 0 && L > 0) ? int'($urandom_range(0, L - 1)) : -1;
      fill_rand(L);
      send_frame(L, er, 9'($urandom), ($urandom_range(0, 6) != 0), -1);
    end

    repeat (10) cyc(1'b0, 8'h00, 1'b0);
    chk("wq_empty",    150'(wq.size()),   150'd0);
    chk("dq_empty",    150'(dq.size()),   150'd0);
    chk("relq_empty",  150'(relq.size()), 150'd0);
    chk("rd_count",    150'(rd_seen),     150'(rd_exp));
    chk("nobuf_count", 150'(nobuf_seen),  150'(nobuf_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
